sw_s2p: RTL



---
 rtl/sw_s2p.sv | 86 ++++++++
 1 files changed

// File: rtl/sw_s2p.sv
// sw_s2p: serial-to-parallel capture from a 74HC165-style switch chain, MSB first.
// Define SW_S2P_INVERT_EN to present the captured word inverted (active-low switches read as 1).
module sw_s2p #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4,
  parameter int PHASE_CYCLES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic                 sin,
  output logic                 sr_clk,
  output logic                 sr_load_n,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] P_Data
);
  localparam int PW = $clog2(PHASE_CYCLES);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;
  state_t                     r_state, w_nxt;
  logic [PW-1:0]              r_ph;
  logic [DATA_COUNT_BITS-1:0] r_bit;
  logic [DATA_BITS-2:0]       r_shreg;
  logic [DATA_BITS-1:0]       w_word;
  logic                       w_ph_last, w_bit_last, w_sample;
  logic                       r_sclk, r_load_n, r_busy, r_done;
  logic                       w_sclk, w_load_n, w_busy, w_done;
  assign w_ph_last  = r_ph == PW'(PHASE_CYCLES - 1);
  assign w_bit_last = r_bit == DATA_COUNT_BITS'(DATA_BITS - 1);
  assign w_sample   = r_state == SHIFT_LO && w_ph_last;
  // The live sin bit is folded in so the word is complete on the edge entering DONE.
  assign w_word     = {r_shreg, sin};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     w_nxt = Start ? LOAD : IDLE;
      LOAD:     w_nxt = w_ph_last ? SHIFT_LO : LOAD;
      SHIFT_LO: w_nxt = !w_ph_last ? SHIFT_LO : (w_bit_last ? DONE : SHIFT_HI);
      SHIFT_HI: w_nxt = w_ph_last ? SHIFT_LO : SHIFT_HI;
      DONE:     w_nxt = Start ? LOAD : IDLE;
      default:  w_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_load_n = w_nxt != LOAD;
    w_sclk   = w_nxt == SHIFT_HI;
    w_busy   = w_nxt != IDLE;
    w_done   = w_nxt == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk   <= 1'b0;
      r_load_n <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_sclk   <= w_sclk;
      r_load_n <= w_load_n;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ph    <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      P_Data  <= '0;
    end else begin
      r_ph <= (w_nxt != r_state || r_state == IDLE) ? '0 : r_ph + PW'(1);
      if (r_state == LOAD) r_bit <= '0;
      else if (w_sample) r_bit <= r_bit + DATA_COUNT_BITS'(1);
      if (w_sample) r_shreg <= w_word[DATA_BITS-2:0];
`ifdef SW_S2P_INVERT_EN
      if (w_nxt == DONE) P_Data <= ~w_word;
`else
      if (w_nxt == DONE) P_Data <= w_word;
`endif
    end
  assign sr_clk    = r_sclk;
  assign sr_load_n = r_load_n;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
